// File: rtl/fft_input_framer_if.sv
`default_nettype none
// ============================================================================
// fft_input_framer_if : sample-stream and frame handshake bundle for the framer
// Rev 1.0
// ============================================================================
interface fft_input_framer_if #(
   parameter int N = 3,
   parameter int W = 32
);
   logic [W-1:0]          s_data;
   logic                  s_valid;
   logic                  s_last;
   logic                  s_ready;
   logic [W*(2**N)-1:0]   frame_out;
   logic                  frame_valid;
   logic                  frame_ready;
   logic                  align_err;
   logic [1:0]            frames_held;

   modport master (
      output s_data, s_valid, s_last, frame_ready,
      input  s_ready, frame_out, frame_valid, align_err, frames_held
   );

   modport slave (
      input  s_data, s_valid, s_last, frame_ready,
      output s_ready, frame_out, frame_valid, align_err, frames_held
   );
endinterface
`default_nettype wire

// File: rtl/fft_input_framer.sv
`default_nettype none
// ============================================================================
// fft_input_framer : packs 2**N serial complex samples into ping-pong frame banks
// Rev 1.0
// ============================================================================
module fft_input_framer #(
   parameter int N = 3,
   parameter int W = 32
) (
   input  wire logic        clk,
   input  wire logic        rst,
   fft_input_framer_if.slave bus
);
   localparam int             c_DEPTH    = 2**N;
   localparam logic [N-1:0]   c_LAST_IDX = N'(c_DEPTH - 1);

   logic [1:0][c_DEPTH-1:0][W-1:0] r_bank;
   logic [1:0]                     r_full;
   logic                           r_wr_bank;
   logic                           r_rd_bank;
   logic [N-1:0]                   r_wr_cnt;
   logic                           r_align_err;

   logic                           w_ready;
   logic                           w_accept;
   logic                           w_cnt_last;
   logic                           w_release;
   logic                           w_frame_done;
   logic                           w_misalign;
   logic [1:0]                     w_full_nxt;

   // Ready depends only on state so upstream never sees a valid->ready loop.
   assign w_ready      = ~r_full[r_wr_bank];
   assign w_accept     = bus.s_valid & w_ready;
   assign w_cnt_last   = (r_wr_cnt == c_LAST_IDX);
   assign w_release    = r_full[r_rd_bank] & bus.frame_ready;
   assign w_frame_done = w_accept & w_cnt_last;
   assign w_misalign   = w_accept & (bus.s_last != w_cnt_last);

   // Completion targets an empty bank and release a full one, so they never collide.
   always_comb begin
      w_full_nxt = r_full;
      if (w_release) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
      if (w_frame_done) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank      <= '0;
         r_full      <= 2'b00;
         r_wr_bank   <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_wr_cnt    <= '0;
         r_align_err <= 1'b0;
      end else begin
         r_full      <= w_full_nxt;
         r_align_err <= w_misalign;

         if (w_accept) begin
            r_bank[r_wr_bank][r_wr_cnt] <= bus.s_data;
         end

         if (w_frame_done) begin
            r_wr_bank <= ~r_wr_bank;
            r_wr_cnt  <= '0;
         end else if (w_accept && bus.s_last) begin
            // Early end-of-frame: drop the partial frame and restart in place.
            r_wr_cnt  <= '0;
         end else if (w_accept) begin
            r_wr_cnt  <= r_wr_cnt + 1'b1;
         end

         if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   assign bus.s_ready     = w_ready;
   assign bus.frame_valid = r_full[r_rd_bank];
   assign bus.frame_out   = r_bank[r_rd_bank];
   assign bus.align_err   = r_align_err;
   assign bus.frames_held = {1'b0, r_full[0]} + {1'b0, r_full[1]};

endmodule
`default_nettype wire

// File: tb/tb_fft_input_framer.sv
`default_nettype none
// ============================================================================
// tb_fft_input_framer : scoreboard bench for fft_input_framer
// Rev 1.0
// ============================================================================
module tb_fft_input_framer;
   localparam int N     = 3;
   localparam int W     = 32;
   localparam int DEPTH = 8;
   localparam int FW    = W * DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fft_input_framer_if #(.N(N), .W(W)) bus ();

   logic ready_set = 1'b0;
   logic rnd_en    = 1'b0;
   logic rnd_bit   = 1'b0;
   assign bus.frame_ready = rnd_en ? rnd_bit : ready_set;

   fft_input_framer #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int vectors     = 0;
   int errors      = 0;
   int stalls      = 0;
   int frames_seen = 0;
   logic [31:0] seq = 32'd0;

   logic [FW-1:0]                exp_q[$];
   logic [DEPTH-1:0][W-1:0]      m_cur;
   int                           m_cnt = 0;
   logic                         m_al  = 1'b0;

   always begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   // Reference model: queue of completed frames stands in for the bank pair.
   always @(negedge clk) begin
      int  held;
      logic can_acc;
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
         m_al  = 1'b0;
      end else begin
         held    = exp_q.size();
         can_acc = (held < 2);
         vectors++;
         if (bus.frames_held !== 2'(held) || bus.frame_valid !== (held != 0) ||
             bus.s_ready !== can_acc) begin
            errors++;
            $display("FAIL status: held=%0d valid=%b ready=%b, required held=%0d valid=%b ready=%b",
                     bus.frames_held, bus.frame_valid, bus.s_ready, held, (held != 0), can_acc);
         end
         vectors++;
         if (bus.align_err !== m_al) begin
            errors++;
            $display("FAIL align_err: got %b, required %b", bus.align_err, m_al);
         end
         m_al = 1'b0;
         if (held != 0 && bus.frame_ready) begin
            vectors++;
            if (bus.frame_out !== exp_q[0]) begin
               errors++;
               $display("FAIL frame_out: got %h, required %h", bus.frame_out, exp_q[0]);
            end
            void'(exp_q.pop_front());
            frames_seen++;
         end
         if (bus.s_valid && can_acc) begin
            m_cur[m_cnt] = bus.s_data;
            if (m_cnt == DEPTH - 1) begin
               exp_q.push_back(m_cur);
               m_cnt = 0;
               m_al  = !bus.s_last;
            end else if (bus.s_last) begin
               m_cnt = 0;
               m_al  = 1'b1;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   function automatic logic [31:0] next_data();
      seq = seq + 1;
      return 32'hC000_0000 | seq;
   endfunction

   task automatic send(input logic [W-1:0] d, input logic l);
      int guard = 0;
      bus.s_data  = d;
      bus.s_last  = l;
      bus.s_valid = 1'b1;
      @(negedge clk);
      while (bus.s_ready !== 1'b1 && guard < 200) begin
         stalls++;
         guard++;
         @(negedge clk);
      end
      if (guard >= 200) begin
         vectors++;
         errors++;
         $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", bus.s_ready, guard);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check1(input string name, input logic got, input logic req);
      vectors++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      vectors++;
      if (bus.s_ready !== 1'b1 || bus.frame_valid !== 1'b0 || bus.frame_out !== '0 ||
          bus.align_err !== 1'b0 || bus.frames_held !== 2'd0) begin
         errors++;
         $display("FAIL %s: ready=%b valid=%b out=%h err=%b held=%0d, required 1 0 0 0 0",
                  tag, bus.s_ready, bus.frame_valid, bus.frame_out, bus.align_err, bus.frames_held);
      end
   endtask

   task automatic drain();
      int guard = 0;
      ready_set = 1'b1;
      idle(1);
      while (exp_q.size() != 0 && guard < 50) begin
         guard++;
         @(posedge clk);
         #1;
      end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d frames left, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = '0;
      rst         = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("reset_released");
   endtask

   task automatic test_basic();
      ready_set = 1'b1;
      for (int k = 1; k <= 7; k++) send(32'(k) << 16, 1'b0);
      check1("basic_valid_before_last", bus.frame_valid, 1'b0);
      send(32'h0008_0000, 1'b1);
      bus.s_valid = 1'b0;
      check1("basic_valid_after_last", bus.frame_valid, 1'b1);
      vectors++;
      if (bus.frame_out[31:0] !== 32'h0001_0000 || bus.frame_out[255:224] !== 32'h0008_0000) begin
         errors++;
         $display("FAIL basic_frame_ends: got %h/%h, required 00010000/00080000",
                  bus.frame_out[31:0], bus.frame_out[255:224]);
      end
      check1("basic_align", bus.align_err, 1'b0);
      idle(2);
   endtask

   task automatic test_full();
      logic [31:0] d;
      logic [31:0] second_first = '0;
      ready_set = 1'b0;
      for (int i = 0; i < 16; i++) begin
         d = next_data();
         if (i == 8) second_first = d;
         send(d, (i % 8) == 7);
      end
      check1("full_ready_low", bus.s_ready, 1'b0);
      vectors++;
      if (bus.frames_held !== 2'd2) begin
         errors++;
         $display("FAIL full_held: got %0d, required 2", bus.frames_held);
      end
      d = next_data();
      bus.s_data  = d;
      bus.s_last  = 1'b0;
      bus.s_valid = 1'b1;
      @(posedge clk);
      #1;
      ready_set = 1'b1;
      check1("full_release_cycle_ready", bus.s_ready, 1'b0);
      @(posedge clk);
      #1;
      ready_set = 1'b0;
      check1("full_ready_back", bus.s_ready, 1'b1);
      vectors++;
      if (bus.frames_held !== 2'd1 || bus.frame_out[31:0] !== second_first) begin
         errors++;
         $display("FAIL full_after_release: held=%0d first=%h, required 1 %h",
                  bus.frames_held, bus.frame_out[31:0], second_first);
      end
      send(d, 1'b0);
      for (int i = 1; i < 8; i++) send(next_data(), i == 7);
      idle(1);
      vectors++;
      if (bus.frames_held !== 2'd2) begin
         errors++;
         $display("FAIL full_third: held=%0d, required 2", bus.frames_held);
      end
      drain();
   endtask

   task automatic test_stream();
      int s0 = stalls;
      int f0 = frames_seen;
      ready_set = 1'b1;
      for (int i = 0; i < 64; i++) send(next_data(), (i % 8) == 7);
      idle(3);
      vectors++;
      if (stalls - s0 != 0 || frames_seen - f0 != 8) begin
         errors++;
         $display("FAIL stream: stalls=%0d frames=%0d, required 0 8", stalls - s0, frames_seen - f0);
      end
   endtask

   task automatic test_align();
      logic [31:0] d;
      logic [31:0] sixth = '0;
      ready_set = 1'b1;
      for (int i = 0; i < 4; i++) send(next_data(), 1'b0);
      send(next_data(), 1'b1);
      bus.s_valid = 1'b0;
      check1("early_last_pulse", bus.align_err, 1'b1);
      @(posedge clk);
      #1;
      check1("early_last_pulse_end", bus.align_err, 1'b0);
      for (int i = 0; i < 8; i++) begin
         d = next_data();
         if (i == 0) sixth = d;
         send(d, i == 7);
      end
      bus.s_valid = 1'b0;
      vectors++;
      if (bus.frame_valid !== 1'b1 || bus.frame_out[31:0] !== sixth || bus.align_err !== 1'b0) begin
         errors++;
         $display("FAIL realign_frame: valid=%b first=%h err=%b, required 1 %h 0",
                  bus.frame_valid, bus.frame_out[31:0], bus.align_err, sixth);
      end
      idle(1);
      for (int i = 0; i < 8; i++) send(next_data(), 1'b0);
      bus.s_valid = 1'b0;
      check1("missing_last_pulse", bus.align_err, 1'b1);
      check1("missing_last_frame", bus.frame_valid, 1'b1);
      idle(2);
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      logic [31:0] first = '0;
      ready_set = 1'b0;
      for (int i = 0; i < 13; i++) send(next_data(), i == 7);
      bus.s_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      ready_set = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = next_data();
         if (i == 0) first = d;
         send(d, i == 7);
      end
      bus.s_valid = 1'b0;
      vectors++;
      if (bus.frame_valid !== 1'b1 || bus.frame_out[31:0] !== first || bus.frames_held !== 2'd1) begin
         errors++;
         $display("FAIL post_reset_frame: valid=%b first=%h held=%0d, required 1 %h 1",
                  bus.frame_valid, bus.frame_out[31:0], bus.frames_held, first);
      end
      idle(2);
   endtask

   task automatic test_random();
      int f0 = frames_seen;
      rnd_en = 1'b1;
      for (int f = 0; f < 100; f++) begin
         for (int k = 0; k < 8; k++) begin
            send($urandom, k == 7);
            idle(1);
         end
      end
      rnd_en = 1'b0;
      drain();
      vectors++;
      if (frames_seen - f0 != 100) begin
         errors++;
         $display("FAIL random_frames: got %0d, required 100", frames_seen - f0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_stream();
      test_align();
      test_async_reset();
      test_random();
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fft_input_framer.md
Name: fft_input_framer

Overview:
- Upstream neighbour of the bit-reverse mapper in the 8-point FFT datapath.
- Accepts a serial stream of 32-bit complex samples through a valid/ready handshake and packs each group of 2**N samples into one parallel frame.
- Holds frames in a ping-pong pair of banks so the next frame fills while the current one is held for the mapper.
- Sample format is passed through untouched: real in [31:16], imag in [15:0].

Parameters:
- N, 3, log2 of frame size; frame = 2**N samples.
- W, 32, width of one complex sample.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data  input  W  incoming sample.
- s_valid  input  1  s_data/s_last valid this cycle.
- s_last  input  1  upstream marks last sample of a frame.
- s_ready  output  1  framer can accept a sample this cycle.
- frame_out  output  W*2**N  held frame; sample k (arrival order) at [W*k+W-1 : W*k]; feeds mapper input index k.
- frame_valid  output  1  frame_out holds a complete frame.
- frame_ready  input  1  consumer takes the frame this cycle.
- align_err  output  1  one-cycle pulse on s_last mismatch.
- frames_held  output  2  number of full banks (0..2).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - wr_bank=0, rd_bank=0, wr_cnt=0, bank_full=2'b00, all bank storage=0.
  - Outputs: s_ready=1, frame_valid=0, frame_out=0, align_err=0, frames_held=0.
  - rst asserted mid-frame or with full banks discards everything; no frame is emitted for partial data.
- State:
  - Two banks of 2**N x W registers.
  - Per-bank full flag.
  - wr_bank/rd_bank pointers (1 bit each).
  - wr_cnt (N bits).
- Write side:
  - s_ready = !bank_full[wr_bank], combinational from registers only; no dependence on s_valid.
  - Accept = s_valid && s_ready.
  - On accept: bank[wr_bank][wr_cnt] <= s_data.
    - If wr_cnt == 2**N-1: bank_full[wr_bank] <= 1, wr_bank toggles, wr_cnt <= 0.
    - Otherwise wr_cnt increments.
- Alignment check (on accept only):
  - Early s_last (s_last=1, wr_cnt < 2**N-1):
    - The sample is written, but the partial frame is discarded: wr_cnt <= 0, bank not marked full, wr_bank unchanged.
    - align_err pulses next cycle.
  - Missing s_last (s_last=0, wr_cnt == 2**N-1): frame completes normally; align_err pulses next cycle.
  - s_last is ignored when not accepted.
- Read side:
  - frame_valid = bank_full[rd_bank].
  - frame_out = contents of bank[rd_bank], driven from registers with no extra stage.
  - When frame_valid=0, frame_out shows stale bank[rd_bank] contents. The consumer must qualify with frame_valid.
  - On frame_valid && frame_ready: bank_full[rd_bank] <= 0, rd_bank toggles.
  - frame_ready while frame_valid=0 has no effect.
- Latency:
  - Last sample accepted at edge t -> frame_valid=1 after edge t (visible in cycle t+1).
  - Frame stays stable until released.
- Throughput:
  - One sample per cycle sustained when the consumer releases each frame within 2**N cycles of completion.
  - Back-to-back frames need no bubble.
- Simultaneous events:
  - A frame completion into one bank and a release of the other bank in the same cycle are both honoured.
  - frames_held is updated by +1-1 = unchanged.
  - wr_bank==rd_bank occurs only with both banks empty (no release possible) or both full (s_ready=0, no write possible), so no read/write conflict on a bank exists.
- Full condition:
  - Both banks full -> s_ready=0 until a release.
  - In the release cycle s_ready stays 0; it rises the following cycle.
- frames_held = bank_full[0] + bank_full[1], registered-derived.

Test Plan:
- Reset, then stream samples 0x00010000..0x00080000 (k<<16) with s_last on the 8th, frame_ready=1 -> frame_valid high one cycle after the 8th accept; frame_out[31:0]=0x00010000, [255:224]=0x00080000; align_err stays 0.
- frame_ready=0, push 24 samples continuously -> s_ready drops after the 16th accept; frames_held=2. Raise frame_ready for one cycle -> frames_held=1, rd_bank frame changes to the second frame, s_ready returns next cycle, third frame then fills.
- Continuous 64 samples with frame_ready=1 -> 8 frames, no s_ready deassertion, each frame_out matching its input group in order.
- s_last asserted on 5th sample -> align_err one-cycle pulse; the next 8 samples form a frame starting at sample 6. Separately, s_last missing on the 8th -> frame still emitted, align_err pulses.
- Assert rst after 5 samples, with one full bank held -> all outputs return to reset values immediately (async); the next 8 samples produce a frame at bank 0 with no residue.
- s_valid toggling 1/0 with random frame_ready stalls over 100 frames -> no sample lost or duplicated; frame order preserved; scoreboard compares each frame_out against the input stream.
